// File: rtl/id_stage.sv
// Instruction decode stage: splits a 16-bit instruction into fields, reads two
// operands from a 16x16 register file with writeback forwarding, tracks pending
// register writes in a busy scoreboard, and registers a decode bundle for execute.
module id_stage #(
    parameter bit          SB_EN   = 1'b1,
    parameter logic [15:0] RF_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [3:0]  out_rd,
    output logic [15:0] out_rs1_val,
    output logic [15:0] out_rs2_val,
    output logic [15:0] out_imm,
    output logic        out_we,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_branch,
    output logic        out_jump,
    output logic        out_illegal,
    output logic        halted
);

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [15:0] rs1_val;
        logic [15:0] rs2_val;
        logic [15:0] imm;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bundle_t;

    logic [15:0] rf_q [16];
    logic [15:0] rf_d [16];
    logic [15:0] busy_q, busy_d, busy_eff_s;
    logic        halted_q, halted_d;
    logic        out_valid_q, out_valid_d;
    bundle_t     bundle_q, bundle_d, dec_s;
    logic [3:0]  rs1_idx_s, rs2_idx_s;
    logic        dec_halt_s, stall_s, accept_s;

    // Field decode: destination, source indices, immediate and control flags
    always_comb begin
        dec_s         = '0;
        rs1_idx_s     = 4'd0;
        rs2_idx_s     = 4'd0;
        dec_halt_s    = 1'b0;
        dec_s.opcode  = in_instr[15:12];
        case (in_instr[15:12])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                dec_s.rd = in_instr[11:8];
                dec_s.we = 1'b1;
                rs1_idx_s = in_instr[7:4];
                rs2_idx_s = in_instr[3:0];
            end
            4'h7: begin
                dec_s.rd  = in_instr[11:8];
                dec_s.we  = 1'b1;
                rs1_idx_s = in_instr[7:4];
                dec_s.imm = {{12{in_instr[3]}}, in_instr[3:0]};
            end
            4'h8: begin
                dec_s.rd  = in_instr[11:8];
                dec_s.we  = 1'b1;
                dec_s.imm = {{8{in_instr[7]}}, in_instr[7:0]};
            end
            4'h9: begin
                dec_s.rd     = in_instr[11:8];
                dec_s.we     = 1'b1;
                dec_s.mem_rd = 1'b1;
                rs1_idx_s    = in_instr[7:4];
                dec_s.imm    = {{12{in_instr[3]}}, in_instr[3:0]};
            end
            4'hA: begin
                dec_s.mem_wr = 1'b1;
                rs2_idx_s    = in_instr[11:8];
                rs1_idx_s    = in_instr[7:4];
                dec_s.imm    = {{12{in_instr[3]}}, in_instr[3:0]};
            end
            4'hB: begin
                dec_s.branch = 1'b1;
                rs1_idx_s    = in_instr[11:8];
                rs2_idx_s    = in_instr[7:4];
                dec_s.imm    = {{12{in_instr[3]}}, in_instr[3:0]};
            end
            4'hC: begin
                dec_s.jump = 1'b1;
                dec_s.imm  = {{4{in_instr[11]}}, in_instr[11:0]};
            end
            4'hD, 4'hE: begin
                dec_s.illegal = 1'b1;
            end
            4'hF: begin
                dec_halt_s = 1'b1;
            end
            default: begin
                dec_halt_s = 1'b0;
            end
        endcase
        // Index 0 is never written or marked busy, so unused sources read 0
        if (rs1_idx_s == 4'd0) begin
            dec_s.rs1_val = 16'h0000;
        end else if (wb_en && (wb_addr == rs1_idx_s)) begin
            dec_s.rs1_val = wb_data;
        end else begin
            dec_s.rs1_val = rf_q[rs1_idx_s];
        end
        if (rs2_idx_s == 4'd0) begin
            dec_s.rs2_val = 16'h0000;
        end else if (wb_en && (wb_addr == rs2_idx_s)) begin
            dec_s.rs2_val = wb_data;
        end else begin
            dec_s.rs2_val = rf_q[rs2_idx_s];
        end
    end

    // Hazard check against busy bits as they stand after this cycle's writeback
    always_comb begin
        busy_eff_s = busy_q;
        if (wb_en) begin
            busy_eff_s[wb_addr] = 1'b0;
        end else begin
            busy_eff_s = busy_q;
        end
        if (SB_EN == 1'b1) begin
            stall_s = busy_eff_s[rs1_idx_s] | busy_eff_s[rs2_idx_s] | busy_eff_s[dec_s.rd];
        end else begin
            stall_s = 1'b0;
        end
        in_ready = !halted_q && !stall_s && (!out_valid_q || out_ready);
        accept_s = in_valid && in_ready;
    end

    // Next-state for register file, scoreboard, halt flag and output bundle
    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != 4'd0)) begin
            rf_d[wb_addr] = wb_data;
        end else begin
            rf_d = rf_q;
        end
        rf_d[0] = 16'h0000;

        busy_d = busy_eff_s;
        if (accept_s && dec_s.we && (SB_EN == 1'b1)) begin
            busy_d[dec_s.rd] = 1'b1;
        end else begin
            busy_d = busy_eff_s;
        end
        busy_d[0] = 1'b0;

        halted_d = halted_q | (accept_s & dec_halt_s);

        if (accept_s) begin
            bundle_d    = dec_s;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            bundle_d    = bundle_q;
            out_valid_d = 1'b0;
        end else begin
            bundle_d    = bundle_q;
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= (i == 0) ? 16'h0000 : RF_INIT;
            end
            busy_q      <= 16'h0000;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            rf_q        <= rf_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign halted      = halted_q;
    assign out_opcode  = bundle_q.opcode;
    assign out_rd      = bundle_q.rd;
    assign out_rs1_val = bundle_q.rs1_val;
    assign out_rs2_val = bundle_q.rs2_val;
    assign out_imm     = bundle_q.imm;
    assign out_we      = bundle_q.we;
    assign out_mem_rd  = bundle_q.mem_rd;
    assign out_mem_wr  = bundle_q.mem_wr;
    assign out_branch  = bundle_q.branch;
    assign out_jump    = bundle_q.jump;
    assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push hand-computed
// bundles into a queue; a monitor pops and compares on every consumed bundle.
module tb_id_stage;

    localparam logic [15:0] INIT = 16'h0011;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, out_valid, out_ready, halted;
    logic [15:0] in_instr, wb_data, out_rs1_val, out_rs2_val, out_imm;
    logic [3:0]  wb_addr, out_opcode, out_rd;
    logic        out_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [61:0] exp_q [$];

    id_stage #(.SB_EN(1'b1), .RF_INIT(INIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_we(out_we), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_branch(out_branch), .out_jump(out_jump),
        .out_illegal(out_illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [61:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [15:0] r1, input logic [15:0] r2,
                                       input logic [15:0] imm, input logic [5:0] fl);
        return {op, rd, r1, r2, imm, fl};
    endfunction

    function automatic logic [61:0] act();
        return {out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm,
                out_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Monitor: compare every bundle execute consumes against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL bundle: unexpected bundle %h", act());
            end else begin
                logic [61:0] e;
                e = exp_q.pop_front();
                if (act() === e) pass_cnt++;
                else $display("FAIL bundle: got %h expected %h", act(), e);
            end
        end
    end

    // Present an instruction until accepted (bounded), then push its bundle
    task automatic issue(input string name, input logic [15:0] instr, input logic [61:0] e);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL %s: not accepted within 20 cycles", name);
        end
        in_valid = 1'b0;
        in_instr = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; wb_en = 1'b0;
        wb_addr = 4'd0; wb_data = 16'h0000; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_outputs", {1'b0, halted, act()}, 64'd0);
        @(posedge clk); #1;

        // Reset value of R5 visible through an ADD
        issue("add_r5", 16'h1650, mk(4'h1, 4'd6, INIT, 16'h0000, 16'h0000, 6'b100000));
        issue("li_r3", 16'h83FE, mk(4'h8, 4'd3, 16'h0000, 16'h0000, 16'hFFFE, 6'b100000));

        // RAW on R3: stall until writeback of R3 in the same cycle
        in_valid = 1'b1; in_instr = 16'h1431;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("raw_stall", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h0007;
        @(negedge clk);
        check("raw_release", {63'd0, in_ready}, 64'd1);
        if (in_ready) exp_q.push_back(mk(4'h1, 4'd4, 16'h0007, INIT, 16'h0000, 6'b100000));
        @(posedge clk); #1;
        wb_en = 1'b0; in_valid = 1'b0; in_instr = 16'h0000;
        @(posedge clk); #1;

        // Backpressure: bundle held stable, next instruction blocked
        out_ready = 1'b0;
        issue("addi", 16'h771F, mk(4'h7, 4'd7, INIT, 16'h0000, 16'hFFFF, 6'b100000));
        in_valid = 1'b1; in_instr = 16'hA213;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_stable", {2'b0, out_valid, out_rd, out_imm}, {2'b0, 1'b1, 4'd7, 16'hFFFF});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue("st", 16'hA213, mk(4'hA, 4'd0, INIT, INIT, 16'h0003, 6'b001000));

        issue("ld", 16'h9818, mk(4'h9, 4'd8, INIT, 16'h0000, 16'hFFF8, 6'b110000));
        issue("beq", 16'hB125, mk(4'hB, 4'd0, INIT, INIT, 16'h0005, 6'b000100));
        issue("jmp", 16'hC800, mk(4'hC, 4'd0, 16'h0000, 16'h0000, 16'hF800, 6'b000010));
        issue("illegal", 16'hD123, mk(4'hD, 4'd0, 16'h0000, 16'h0000, 16'h0000, 6'b000001));

        // Writeback to R0 ignored, R0 never busy
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hBEEF;
        @(posedge clk); #1;
        wb_en = 1'b0;
        issue("add_r0", 16'h1900, mk(4'h1, 4'd9, 16'h0000, 16'h0000, 16'h0000, 6'b100000));

        // Write-through forwarding of R2 in the accept cycle
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h1234;
        issue("xor_fwd", 16'h5B21, mk(4'h5, 4'd11, 16'h1234, INIT, 16'h0000, 6'b100000));
        wb_en = 1'b0;

        // HALT: bundle passes as NOP, stage then refuses input
        issue("halt", 16'hF000, mk(4'hF, 4'd0, 16'h0000, 16'h0000, 16'h0000, 6'b000000));
        in_valid = 1'b1; in_instr = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("halt_block", {62'd0, halted, in_ready}, {62'd0, 1'b1, 1'b0});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst2_state", {61'd0, halted, out_valid, in_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1;
        // R3 and R2 return to the reset value
        issue("add_after_rst", 16'h1C32, mk(4'h1, 4'd12, INIT, INIT, 16'h0000, 6'b100000));

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
